// File: rtl/aes128_cbc_dec_chain_if.sv
// ---------------------------------------------------------------------------
// aes128_cbc_dec_chain_if
// Bundles every non-clock, non-reset signal of aes128_cbc_dec_chain:
//   vector_0..vector_3, iv_load        IV words (vector_0 = IV[31:0]) and load pulse
//   ct_valid/ct_ready/ct_word/ct_last  ciphertext word stream in
//   core_start/core_block_in           request to the external inverse-cipher core
//   core_done/core_block_out           result from the inverse-cipher core
//   pt_valid/pt_ready/pt_word/pt_last  plaintext word stream out
//   busy, err_timeout                  status
// Modports:
//   slave  - the chaining controller itself
//   master - the surrounding environment (sources, core, sink)
// ---------------------------------------------------------------------------
interface aes128_cbc_dec_chain_if;
    logic [31:0]  vector_0;
    logic [31:0]  vector_1;
    logic [31:0]  vector_2;
    logic [31:0]  vector_3;
    logic         iv_load;
    logic         ct_valid;
    logic         ct_ready;
    logic [31:0]  ct_word;
    logic         ct_last;
    logic         core_start;
    logic [127:0] core_block_in;
    logic         core_done;
    logic [127:0] core_block_out;
    logic         pt_valid;
    logic         pt_ready;
    logic [31:0]  pt_word;
    logic         pt_last;
    logic         busy;
    logic         err_timeout;

    modport slave (
        input  vector_0, vector_1, vector_2, vector_3, iv_load,
        input  ct_valid, ct_word, ct_last,
        output ct_ready,
        output core_start, core_block_in,
        input  core_done, core_block_out,
        output pt_valid, pt_word, pt_last,
        input  pt_ready,
        output busy, err_timeout
    );

    modport master (
        output vector_0, vector_1, vector_2, vector_3, iv_load,
        output ct_valid, ct_word, ct_last,
        input  ct_ready,
        input  core_start, core_block_in,
        output core_done, core_block_out,
        input  pt_valid, pt_word, pt_last,
        output pt_ready,
        input  busy, err_timeout
    );
endinterface

// File: rtl/aes128_cbc_dec_chain.sv
// ---------------------------------------------------------------------------
// aes128_cbc_dec_chain
// Sequential AES-128 CBC decryption chaining controller. Collects four 32-bit
// ciphertext words into a block (word k = block[32k+31:32k]), hands the block
// to an external inverse-cipher core with a one-cycle start pulse, XORs the
// core result with the previous ciphertext block (or the IV) and streams the
// plaintext out as four 32-bit words. Blocks are processed strictly one at a
// time.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous, active-low reset
//   bus    - aes128_cbc_dec_chain_if.slave (IV, ct stream, core handshake,
//            pt stream, busy, err_timeout)
//
// Parameters:
//   TIMEOUT_CYCLES - core_done watchdog limit in cycles (watchdog build only)
//
// Optional feature macro: AES_CBC_DEC_TIMEOUT_EN
//   Defined   - a watchdog in the wait state drops a block whose core result
//               has not arrived within TIMEOUT_CYCLES and sets a sticky
//               err_timeout.
//   Undefined - the controller waits for core_done indefinitely and
//               err_timeout is constant 0.
// ---------------------------------------------------------------------------
module aes128_cbc_dec_chain #(
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    aes128_cbc_dec_chain_if.slave bus
);

    typedef enum logic [1:0] {
        S_COLLECT,
        S_START,
        S_WAIT,
        S_EMIT
    } state_t;

    state_t       state;
    logic [1:0]   cnt;
    logic [127:0] iv_reg;
    logic [127:0] chain_reg;
    logic [127:0] ct_block;
    logic [127:0] pt_reg;
    logic         last_f;

    logic         ct_ready_q;
    logic         core_start_q;
    logic         pt_valid_q;
    logic [31:0]  pt_word_q;
    logic         pt_last_q;
    logic         busy_q;
    logic         err_q;

    logic [127:0] iv_in;
    logic [127:0] core_result;
    logic [1:0]   cnt_nxt;

    assign iv_in       = {bus.vector_3, bus.vector_2, bus.vector_1, bus.vector_0};
    assign core_result = bus.core_block_out ^ chain_reg;
    assign cnt_nxt     = cnt + 2'd1;

`ifdef AES_CBC_DEC_TIMEOUT_EN
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TIMER_W-1:0] timer;
`else
    // Watchdog compiled out: the flag is a constant zero for any legal
    // (non-negative) TIMEOUT_CYCLES.
    assign err_q = (TIMEOUT_CYCLES < 0);
`endif

    // Block control FSM. All stream and core outputs are registered; ct_block
    // doubles as core_block_in, so it stays stable from START until core_done
    // because no new ciphertext is accepted before the block has been emitted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_COLLECT;
            cnt          <= 2'd0;
            iv_reg       <= '0;
            chain_reg    <= '0;
            ct_block     <= '0;
            pt_reg       <= '0;
            last_f       <= 1'b0;
            ct_ready_q   <= 1'b0;
            core_start_q <= 1'b0;
            pt_valid_q   <= 1'b0;
            pt_word_q    <= '0;
            pt_last_q    <= 1'b0;
            busy_q       <= 1'b0;
`ifdef AES_CBC_DEC_TIMEOUT_EN
            timer        <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            core_start_q <= 1'b0;
            case (state)
                S_COLLECT: begin
                    ct_ready_q <= 1'b1;
                    // A new IV is only taken between blocks; it may share the
                    // cycle with the first ciphertext handshake.
                    if (bus.iv_load && cnt == 2'd0) begin
                        iv_reg    <= iv_in;
                        chain_reg <= iv_in;
                    end
                    if (ct_ready_q && bus.ct_valid) begin
                        ct_block[{cnt, 5'd0} +: 32] <= bus.ct_word;
                        busy_q <= 1'b1;
                        if (cnt == 2'd3) begin
                            last_f       <= bus.ct_last;
                            cnt          <= 2'd0;
                            ct_ready_q   <= 1'b0;
                            core_start_q <= 1'b1;
                            state        <= S_START;
                        end else begin
                            cnt <= cnt_nxt;
                        end
                    end
                end

                S_START: begin
`ifdef AES_CBC_DEC_TIMEOUT_EN
                    timer <= '0;
`endif
                    state <= S_WAIT;
                end

                S_WAIT: begin
                    if (bus.core_done) begin
                        pt_reg     <= core_result;
                        // After the final block of a message the chain falls
                        // back to the stored IV for the next message.
                        chain_reg  <= last_f ? iv_reg : ct_block;
                        pt_valid_q <= 1'b1;
                        pt_word_q  <= core_result[31:0];
                        pt_last_q  <= 1'b0;
                        state      <= S_EMIT;
                    end
`ifdef AES_CBC_DEC_TIMEOUT_EN
                    else if (timer == TIMER_W'(TIMEOUT_CYCLES - 1)) begin
                        err_q      <= 1'b1;
                        chain_reg  <= iv_reg;
                        cnt        <= 2'd0;
                        ct_ready_q <= 1'b1;
                        busy_q     <= 1'b0;
                        state      <= S_COLLECT;
                    end else begin
                        timer <= timer + 1'b1;
                    end
`endif
                end

                S_EMIT: begin
                    if (bus.pt_ready) begin
                        if (cnt == 2'd3) begin
                            cnt        <= 2'd0;
                            pt_valid_q <= 1'b0;
                            pt_last_q  <= 1'b0;
                            ct_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state      <= S_COLLECT;
                        end else begin
                            cnt       <= cnt_nxt;
                            pt_word_q <= pt_reg[{cnt_nxt, 5'd0} +: 32];
                            pt_last_q <= last_f && (cnt_nxt == 2'd3);
                        end
                    end
                end

                default: begin
                    state <= S_COLLECT;
                end
            endcase
        end
    end

    assign bus.ct_ready      = ct_ready_q;
    assign bus.core_start    = core_start_q;
    assign bus.core_block_in = ct_block;
    assign bus.pt_valid      = pt_valid_q;
    assign bus.pt_word       = pt_word_q;
    assign bus.pt_last       = pt_last_q;
    assign bus.busy          = busy_q;
    assign bus.err_timeout   = err_q;

endmodule

// File: tb/tb_aes128_cbc_dec_chain.sv
// ---------------------------------------------------------------------------
// tb_aes128_cbc_dec_chain
// Self-checking bench for aes128_cbc_dec_chain. A behavioural core model
// answers each core_start five cycles later with core_block_in XOR all-ones.
// Expected plaintext comes from a block-level CBC model:
//   pt = D(ct) ^ chain, chain = last ? iv : ct
// Directed scenarios are followed by randomized blocks, IV loads and
// stream back-pressure. Watchdog scenario is built when AES_CBC_DEC_TIMEOUT_EN
// is defined.
// ---------------------------------------------------------------------------
module tb_aes128_cbc_dec_chain;

    localparam logic [127:0] ONES = {128{1'b1}};

    logic clk;
    logic reset;

    int checks = 0;
    int errors = 0;

    logic [127:0] model_iv;
    logic [127:0] model_chain;

    logic core_stall;
    logic core_busy;
    logic expect_pt_after_done;

    aes128_cbc_dec_chain_if bus();

    aes128_cbc_dec_chain #(.TIMEOUT_CYCLES(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // Behavioural inverse-cipher core: result = block ^ ones, done 5 cycles
    // after the start pulse; then pt_valid must follow one cycle later.
    logic [127:0] core_capture;
    initial begin
        bus.core_done      = 1'b0;
        bus.core_block_out = '0;
        core_busy          = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.core_start === 1'b1 && !core_stall) begin
                core_busy    = 1'b1;
                core_capture = bus.core_block_in;
                repeat (5) @(posedge clk);
                #1;
                bus.core_done      = 1'b1;
                bus.core_block_out = core_capture ^ ONES;
                @(posedge clk);
                #1;
                bus.core_done = 1'b0;
                checkOutput("pt_valid_after_done", {127'd0, bus.pt_valid},
                            {127'd0, expect_pt_after_done});
                core_busy = 1'b0;
            end
        end
    end

    // Sends one ciphertext block; optionally pulses iv_load with word iv_at.
    task automatic applyStimulus(input logic [127:0] ct, input logic last,
                                 input int iv_at, input logic [127:0] iv_val);
        for (int w = 0; w < 4; w++) begin
            int gaps;
            int guard;
            gaps = $urandom_range(0, 2);
            bus.ct_valid = 1'b0;
            repeat (gaps) begin
                @(posedge clk);
                #1;
            end
            bus.ct_valid = 1'b1;
            bus.ct_word  = ct[32*w +: 32];
            bus.ct_last  = (w == 3) ? last : ($urandom_range(0, 1) == 1);
            if (w == iv_at) begin
                bus.iv_load = 1'b1;
                {bus.vector_3, bus.vector_2, bus.vector_1, bus.vector_0} = iv_val;
            end
            guard = 0;
            while (bus.ct_ready !== 1'b1 && guard < 50) begin
                @(posedge clk);
                #1;
                guard++;
            end
            if (guard >= 50) begin
                checkOutput("ct_ready_wait", {127'd0, bus.ct_ready}, 128'd1);
                bus.ct_valid = 1'b0;
                bus.iv_load  = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            bus.iv_load = 1'b0;
            if (w < 3) checkOutput("busy_collect", {127'd0, bus.busy}, 128'd1);
        end
        bus.ct_valid = 1'b0;
        bus.ct_last  = 1'b0;
    endtask

    // Receives four plaintext words and compares them with the model block.
    task automatic receiveBlock(input logic [127:0] exp, input logic last,
                                input int hold_word, input int hold_cycles,
                                output logic [127:0] got);
        got = '0;
        for (int w = 0; w < 4; w++) begin
            int guard;
            int stall;
            guard = 0;
            bus.pt_ready = 1'b0;
            while (bus.pt_valid !== 1'b1 && guard < 50) begin
                @(posedge clk);
                #1;
                guard++;
            end
            if (guard >= 50) begin
                checkOutput("pt_valid_wait", {127'd0, bus.pt_valid}, 128'd1);
                return;
            end
            if (w == hold_word) begin
                repeat (hold_cycles) begin
                    @(posedge clk);
                    #1;
                    checkOutput("hold_pt_valid", {127'd0, bus.pt_valid}, 128'd1);
                    checkOutput("hold_pt_word", {96'd0, bus.pt_word},
                                {96'd0, exp[32*w +: 32]});
                    checkOutput("hold_ct_ready", {127'd0, bus.ct_ready}, 128'd0);
                end
            end else begin
                stall = $urandom_range(0, 2);
                repeat (stall) begin
                    @(posedge clk);
                    #1;
                end
            end
            checkOutput("pt_word", {96'd0, bus.pt_word}, {96'd0, exp[32*w +: 32]});
            checkOutput("pt_last", {127'd0, bus.pt_last},
                        {127'd0, (last && w == 3)});
            got[32*w +: 32] = bus.pt_word;
            bus.pt_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.pt_ready = 1'b0;
        end
        checkOutput("ct_ready_idle", {127'd0, bus.ct_ready}, 128'd1);
        checkOutput("busy_idle", {127'd0, bus.busy}, 128'd0);
    endtask

    // Full block: model update, send, start-pulse checks, receive.
    task automatic runBlock(input logic [127:0] ct, input logic last,
                            input int iv_at, input logic [127:0] iv_val,
                            input int hold_word, input int hold_cycles,
                            output logic [127:0] got);
        logic [127:0] exp;
        if (iv_at == 0) begin
            model_iv    = iv_val;
            model_chain = iv_val;
        end
        exp         = (ct ^ ONES) ^ model_chain;
        model_chain = last ? model_iv : ct;
        applyStimulus(ct, last, iv_at, iv_val);
        checkOutput("core_start", {127'd0, bus.core_start}, 128'd1);
        checkOutput("core_block_in", bus.core_block_in, ct);
        checkOutput("ct_ready_blocked", {127'd0, bus.ct_ready}, 128'd0);
        @(posedge clk);
        #1;
        checkOutput("core_start_pulse", {127'd0, bus.core_start}, 128'd0);
        receiveBlock(exp, last, hold_word, hold_cycles, got);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ctrl"},
                    {122'd0, bus.ct_ready, bus.core_start, bus.pt_valid,
                     bus.pt_last, bus.busy, bus.err_timeout}, 128'd0);
        checkOutput({tag, "_pt_word"}, {96'd0, bus.pt_word}, 128'd0);
        checkOutput({tag, "_core_block_in"}, bus.core_block_in, 128'd0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        logic [127:0] got;
        logic [127:0] ct;
        logic [127:0] iv;
        logic         last;
        int           iv_at;
        int           guard;

        reset                = 1'b0;
        core_stall           = 1'b0;
        expect_pt_after_done = 1'b1;
        bus.vector_0 = '0;
        bus.vector_1 = '0;
        bus.vector_2 = '0;
        bus.vector_3 = '0;
        bus.iv_load  = 1'b0;
        bus.ct_valid = 1'b0;
        bus.ct_word  = '0;
        bus.ct_last  = 1'b0;
        bus.pt_ready = 1'b0;
        model_iv     = '0;
        model_chain  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ct_ready_after_reset", {127'd0, bus.ct_ready}, 128'd1);

        // 1: IV load then zero block, not last
        $display("[TB] directed: first block after IV load");
        bus.iv_load = 1'b1;
        {bus.vector_3, bus.vector_2, bus.vector_1, bus.vector_0} =
            128'h0102030405060708090A0B0C0D0E0F10;
        @(posedge clk);
        #1;
        bus.iv_load = 1'b0;
        model_iv    = 128'h0102030405060708090A0B0C0D0E0F10;
        model_chain = model_iv;
        runBlock(128'h0, 1'b0, -1, '0, -1, 0, got);
        checkOutput("t1_pt_block", got, 128'hFEFDFCFB_FAF9F8F7_F6F5F4F3_F2F1F0EF);

        // 2: zero block marked last, chained from ct=0
        runBlock(128'h0, 1'b1, -1, '0, -1, 0, got);
        checkOutput("t2_pt_block", got, ONES);

        // 3+4: IV restored after last block; output held under back-pressure
        runBlock(128'h0, 1'b0, -1, '0, 1, 3, got);
        checkOutput("t3_first_word", {96'd0, got[31:0]}, 128'hF2F1F0EF);

        // 5: iv_load mid-block is ignored
        ct = {$urandom, $urandom, $urandom, $urandom};
        runBlock(ct, 1'b0, 2, ONES, -1, 0, got);
        checkOutput("t5_iv_ignored", got, (ct ^ ONES) ^ 128'h0);

        // 6: asynchronous reset during WAIT, late core_done ignored
        $display("[TB] directed: reset during core wait");
        ct = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(ct, 1'b0, -1, '0);
        checkOutput("t6_core_start", {127'd0, bus.core_start}, 128'd1);
        expect_pt_after_done = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        #1;
        checkAllZero("async_reset");
        model_iv    = '0;
        model_chain = '0;
        @(posedge clk);
        #4 reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("t6_ct_ready_release", {127'd0, bus.ct_ready}, 128'd1);
        guard = 0;
        while (core_busy && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        expect_pt_after_done = 1'b1;
        checkOutput("t6_late_done_pt_valid", {127'd0, bus.pt_valid}, 128'd0);
        checkOutput("t6_late_done_busy", {127'd0, bus.busy}, 128'd0);
        runBlock({$urandom, $urandom, $urandom, $urandom}, 1'b0, -1, '0, -1, 0, got);
        runBlock({$urandom, $urandom, $urandom, $urandom}, 1'b1, 0,
                 {$urandom, $urandom, $urandom, $urandom}, -1, 0, got);

`ifdef AES_CBC_DEC_TIMEOUT_EN
        // Watchdog: stalled core drops the block and sets the sticky flag
        $display("[TB] directed: core watchdog");
        core_stall = 1'b1;
        applyStimulus({$urandom, $urandom, $urandom, $urandom}, 1'b0, -1, '0);
        guard = 0;
        while (bus.err_timeout !== 1'b1 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        checkOutput("timeout_cycles", 128'(guard), 128'd33);
        checkOutput("timeout_pt_valid", {127'd0, bus.pt_valid}, 128'd0);
        @(posedge clk);
        #1;
        checkOutput("timeout_ct_ready", {127'd0, bus.ct_ready}, 128'd1);
        checkOutput("timeout_sticky", {127'd0, bus.err_timeout}, 128'd1);
        core_stall  = 1'b0;
        model_chain = model_iv;
        runBlock({$urandom, $urandom, $urandom, $urandom}, 1'b0, -1, '0, -1, 0, got);
        checkOutput("timeout_still_sticky", {127'd0, bus.err_timeout}, 128'd1);
`else
        checkOutput("err_timeout_off", {127'd0, bus.err_timeout}, 128'd0);
`endif

        // Randomized blocks, message boundaries and IV loads
        $display("[TB] randomized blocks");
        for (int b = 0; b < 12; b++) begin
            int r;
            ct   = {$urandom, $urandom, $urandom, $urandom};
            iv   = {$urandom, $urandom, $urandom, $urandom};
            last = ($urandom_range(0, 3) == 0);
            r    = $urandom_range(0, 3);
            iv_at = (r == 0) ? 0 : ((r == 1) ? 2 : -1);
            runBlock(ct, last, iv_at, iv, $urandom_range(0, 3),
                     $urandom_range(0, 2), got);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes128_cbc_dec_chain.md
Name: aes128_cbc_dec_chain

Overview:
Sequential CBC decryption chaining controller, the receive-side counterpart of the CBC encrypt path in aes128_cbc_top. It accepts a ciphertext stream in 32-bit words and hands each 128-bit block to an external AES-128 inverse-cipher core through a start/done handshake. It XORs the core output with the previous ciphertext block (or the IV) and streams the plaintext out in 32-bit words. Word k always carries bits [32k+31:32k] of a block, consistent with the _0.._3 split used by aes128_cbc_top.

Parameters:
TIMEOUT_CYCLES, 32, core_done watchdog limit in cycles (used only with the optional feature).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
vector_0..vector_3  in  32 each  IV words; vector_0 = IV[31:0]
iv_load  in  1  one-cycle pulse that loads the IV
ct_valid  in  1  ciphertext word valid
ct_ready  out  1  ciphertext word accepted when ct_valid and ct_ready are both high
ct_word  in  32  ciphertext word; the first word is block[31:0]
ct_last  in  1  sampled on the 4th word of a block; marks the final block of a message
core_start  out  1  single-cycle start pulse to the inverse-cipher core
core_block_in  out  128  ciphertext block sent to the core
core_done  in  1  core result valid (single-cycle pulse)
core_block_out  in  128  core inverse-cipher result
pt_valid  out  1  plaintext word valid
pt_ready  in  1  downstream ready
pt_word  out  32  plaintext word
pt_last  out  1  high with word 3 of a block marked last
busy  out  1  high in every state except COLLECT with cnt==0
err_timeout  out  1  sticky watchdog flag; constant 0 when the optional feature is compiled out

Behaviour:
- Reset (reset=0, asynchronous): state=COLLECT, cnt=0, iv_reg=0, chain_reg=0.
  - All outputs 0; core_start drops immediately.
  - After release, ct_ready=1 on the next cycle.
- COLLECT:
  - ct_ready=1.
  - Each ct handshake stores ct_word at index cnt, then cnt++.
  - On the handshake with cnt==3: latch ct_last into last_f, cnt<=0, go to START.
- START:
  - core_start=1 for exactly one cycle.
  - core_block_in = assembled block; it stays stable until core_done.
  - Go to WAIT.
- WAIT:
  - On core_done: pt_reg <= core_block_out ^ chain_reg.
  - chain_reg <= last_f ? iv_reg : ct_block.
  - Go to EMIT.
  - core_done in any other state is ignored.
- EMIT:
  - pt_valid=1, pt_word=pt_reg[32cnt+:32].
  - On pt_ready, cnt++.
  - pt_last = last_f && cnt==3.
  - After the handshake on word 3: cnt<=0, go to COLLECT.
  - pt_word is held stable while pt_ready=0.
- ct_ready=0 in START, WAIT and EMIT. There is no overlap between blocks.
- Latency:
  - core_start rises 1 cycle after the 4th ct handshake.
  - pt_valid rises 1 cycle after core_done is sampled.
- iv_load:
  - Accepted only in COLLECT with cnt==0: iv_reg and chain_reg <= {vector_3,vector_2,vector_1,vector_0}.
  - Ignored in every other case.
  - If iv_load coincides with the first ct handshake, both take effect.
- The chain register reverts to iv_reg after a last block, so the next message starts from the stored IV.

Optional Feature:
AES_CBC_DEC_TIMEOUT_EN
- Defined:
  - A counter runs in WAIT.
  - If core_done has not arrived after TIMEOUT_CYCLES cycles: err_timeout<=1 (sticky until reset), block dropped, chain_reg<=iv_reg, cnt<=0, go to COLLECT, no pt output.
- Undefined:
  - No counter is built; WAIT waits indefinitely.
  - err_timeout is tied to 0.

Test Plan:
Bench core model: core_block_out = core_block_in ^ 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, core_done 5 cycles after core_start.
1. Reset, pulse iv_load with vector=128'h0102030405060708090A0B0C0D0E0F10, send ct=128'h0 (ct_last=0) -> core_start 1 cycle after the 4th word; pt_words F2F1F0EF, F6F5F4F3, FAF9F8F7, FEFDFCFB; pt_last=0.
2. Follow with a second block ct=128'h0 marked ct_last=1 -> pt = all-ones (chained from the previous ct=0); pt_last=1 on word 3 only.
3. Send another block ct=128'h0 without iv_load -> first pt_word=F2F1F0EF (IV restored after the last block).
4. Hold pt_ready=0 for 3 cycles in EMIT -> pt_word and pt_valid held stable; ct_ready stays 0; resumes on pt_ready=1.
5. Pulse iv_load with vector=all-ones after 2 ct words -> ignored; block decrypts using the old chain value; busy=1 throughout.
6. Assert reset=0 during WAIT -> all outputs 0 asynchronously; a late core_done is ignored; a fresh block still works. With AES_CBC_DEC_TIMEOUT_EN and the core model stalled: err_timeout=1 after 32 WAIT cycles, ct_ready=1 on the following cycle.
